e203_exu_flush_sched: RTL and testbench

//  Schedules the single IFU pipe-flush port between three commit-side requesters:

---
 rtl/e203_exu_flush_sched.sv | 178 +++++++++++++++++
 tb/tb_e203_exu_flush_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_flush_sched.sv
// Arbitrates the single IFU flush port between exception, tail-chain trap and branch
// requesters; holds the grant until IFU ack, counts flushes and watches for a lost ack.
module e203_exu_flush_sched #(
  parameter int PC_SIZE = 32,
  parameter int TMO_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               excp_req_i,
  input  logic [PC_SIZE-1:0] excp_op1_i,
  input  logic [PC_SIZE-1:0] excp_op2_i,
  output logic               excp_ack_o,
  input  logic               trap_pulse_i,
  input  logic [PC_SIZE-1:0] trap_op1_i,
  input  logic [PC_SIZE-1:0] trap_op2_i,
  output logic               trap_ack_o,
  input  logic               brch_req_i,
  input  logic [PC_SIZE-1:0] brch_op1_i,
  input  logic [PC_SIZE-1:0] brch_op2_i,
  output logic               brch_ack_o,
  output logic               flush_req_o,
  output logic [PC_SIZE-1:0] flush_op1_o,
  output logic [PC_SIZE-1:0] flush_op2_o,
  output logic [1:0]         flush_src_o,
  input  logic               flush_ack_i,
  output logic               flush_pulse_o,
  output logic               trap_pend_o,
  output logic               trap_drop_o,
  input  logic               cnt_clr_i,
  output logic [CNT_W-1:0]   flush_cnt_o,
  output logic               tmo_err_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_EXCP = 2'd1, SRC_TRAP = 2'd2, SRC_BRCH = 2'd3} src_e;

  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  src_e               src_q, src_d, win_src, cur_src;
  logic [PC_SIZE-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [PC_SIZE-1:0] win_op1, win_op2;
  logic               trap_pend_q, trap_pend_d;
  logic [PC_SIZE-1:0] trap_op1_q, trap_op1_d, trap_op2_q, trap_op2_d;
  logic               trap_drop_q, trap_drop_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Fixed priority winner; the trap competes only through its latched copy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win_src = SRC_NONE;
    win_op1 = '0;
    win_op2 = '0;
    if (excp_req_i) begin
      win_src = SRC_EXCP;
      win_op1 = excp_op1_i;
      win_op2 = excp_op2_i;
    end else if (trap_pend_q) begin
      win_src = SRC_TRAP;
      win_op1 = trap_op1_q;
      win_op2 = trap_op2_q;
    end else if (brch_req_i) begin
      win_src = SRC_BRCH;
      win_op1 = brch_op1_i;
      win_op2 = brch_op2_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    cur_src     = SRC_NONE;
    flush_req_o = 1'b0;
    flush_op1_o = '0;
    flush_op2_o = '0;
    case (state_q)
      S_IDLE: begin
        cur_src     = win_src;
        flush_req_o = (win_src != SRC_NONE);
        flush_op1_o = win_op1;
        flush_op2_o = win_op2;
        if (flush_req_o && !flush_ack_i) begin
          state_d = S_WAIT;
          src_d   = win_src;
          op1_d   = win_op1;
          op2_d   = win_op2;
        end
      end
      S_WAIT: begin
        cur_src     = src_q;
        flush_req_o = 1'b1;
        flush_op1_o = op1_q;
        flush_op2_o = op2_q;
        if (flush_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flush_src_o   = cur_src;
  assign flush_pulse_o = flush_req_o & flush_ack_i;
  assign excp_ack_o    = flush_pulse_o & (cur_src == SRC_EXCP);
  assign trap_ack_o    = flush_pulse_o & (cur_src == SRC_TRAP);
  assign brch_ack_o    = flush_pulse_o & (cur_src == SRC_BRCH);

  // A pulse arriving as the pending trap is consumed refills the latch instead of dropping.
  always_comb begin
    trap_pend_d = trap_pend_q;
    trap_op1_d  = trap_op1_q;
    trap_op2_d  = trap_op2_q;
    trap_drop_d = trap_drop_q;
    if (trap_pulse_i) begin
      if (!trap_pend_q || trap_ack_o) begin
        trap_pend_d = 1'b1;
        trap_op1_d  = trap_op1_i;
        trap_op2_d  = trap_op2_i;
      end else begin
        trap_drop_d = 1'b1;
      end
    end else if (trap_ack_o) begin
      trap_pend_d = 1'b0;
    end
  end

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT)
      tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? TMO_MAX : tmo_cnt_q + TMO_ONE;
    tmo_err_d = tmo_err_q | (tmo_cnt_d == TMO_MAX);

    cnt_d = cnt_q;
    if (cnt_clr_i)                             cnt_d = '0;
    else if (flush_pulse_o && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_q       <= SRC_NONE;
      op1_q       <= '0;
      op2_q       <= '0;
      trap_pend_q <= 1'b0;
      trap_op1_q  <= '0;
      trap_op2_q  <= '0;
      trap_drop_q <= 1'b0;
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      trap_pend_q <= trap_pend_d;
      trap_op1_q  <= trap_op1_d;
      trap_op2_q  <= trap_op2_d;
      trap_drop_q <= trap_drop_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign trap_pend_o = trap_pend_q;
  assign trap_drop_o = trap_drop_q;
  assign tmo_err_o   = tmo_err_q;
  assign flush_cnt_o = cnt_q;

endmodule

// File: tb/tb_e203_exu_flush_sched.sv
// Directed bench for the flush scheduler: arbitration, hold-until-ack, trap latch,
// watchdog, saturating counter and reset abandoning a grant.
module tb_e203_exu_flush_sched;

  localparam int PC_SIZE = 32;
  localparam int TMO_W   = 8;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               excp_req_i, trap_pulse_i, brch_req_i, flush_ack_i, cnt_clr_i;
  logic [PC_SIZE-1:0] excp_op1_i, excp_op2_i, trap_op1_i, trap_op2_i, brch_op1_i, brch_op2_i;
  logic               excp_ack_o, trap_ack_o, brch_ack_o, flush_req_o, flush_pulse_o;
  logic               trap_pend_o, trap_drop_o, tmo_err_o;
  logic [PC_SIZE-1:0] flush_op1_o, flush_op2_o;
  logic [1:0]         flush_src_o;
  logic [CNT_W-1:0]   flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  e203_exu_flush_sched #(.PC_SIZE(PC_SIZE), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .excp_req_i(excp_req_i), .excp_op1_i(excp_op1_i), .excp_op2_i(excp_op2_i), .excp_ack_o(excp_ack_o),
    .trap_pulse_i(trap_pulse_i), .trap_op1_i(trap_op1_i), .trap_op2_i(trap_op2_i), .trap_ack_o(trap_ack_o),
    .brch_req_i(brch_req_i), .brch_op1_i(brch_op1_i), .brch_op2_i(brch_op2_i), .brch_ack_o(brch_ack_o),
    .flush_req_o(flush_req_o), .flush_op1_o(flush_op1_o), .flush_op2_o(flush_op2_o),
    .flush_src_o(flush_src_o), .flush_ack_i(flush_ack_i), .flush_pulse_o(flush_pulse_o),
    .trap_pend_o(trap_pend_o), .trap_drop_o(trap_drop_o), .cnt_clr_i(cnt_clr_i),
    .flush_cnt_o(flush_cnt_o), .tmo_err_o(tmo_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let inputs change and combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    excp_req_i = 0; trap_pulse_i = 0; brch_req_i = 0; flush_ack_i = 0; cnt_clr_i = 0;
    excp_op1_i = '0; excp_op2_i = '0; trap_op1_i = '0; trap_op2_i = '0;
    brch_op1_i = '0; brch_op2_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},  {63'd0, flush_req_o}, 64'd0);
    check({tag, "_src"},  {62'd0, flush_src_o}, 64'd0);
    check({tag, "_op1"},  {32'd0, flush_op1_o}, 64'd0);
    check({tag, "_op2"},  {32'd0, flush_op2_o}, 64'd0);
    check({tag, "_acks"}, {60'd0, excp_ack_o, trap_ack_o, brch_ack_o, flush_pulse_o}, 64'd0);
    check({tag, "_flags"}, {61'd0, trap_pend_o, trap_drop_o, tmo_err_o}, 64'd0);
    check({tag, "_cnt"},  {48'd0, flush_cnt_o}, 64'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    settle();
    check_all_zero("reset");

    // 1: exception acked in the request cycle
    excp_req_i = 1; excp_op1_i = 32'h80; excp_op2_i = 32'h4; flush_ack_i = 1;
    settle();
    check("t1_req", {63'd0, flush_req_o}, 64'd1);
    check("t1_src", {62'd0, flush_src_o}, 64'd1);
    check("t1_ops", {flush_op1_o, flush_op2_o}, {32'h80, 32'h4});
    check("t1_acks", {60'd0, excp_ack_o, trap_ack_o, brch_ack_o, flush_pulse_o}, 64'b1001);
    tick();
    idle_inputs();
    settle();
    check("t1_cnt", {48'd0, flush_cnt_o}, 64'd1);
    check("t1_idle_req", {63'd0, flush_req_o}, 64'd0);

    // 2: branch held in WAIT, higher-priority exception not granted until it finishes
    brch_req_i = 1; brch_op1_i = 32'h200; brch_op2_i = 32'h8;
    settle();
    check("t2_c0_src", {62'd0, flush_src_o}, 64'd3);
    tick();
    check("t2_c1_src", {62'd0, flush_src_o}, 64'd3);
    tick();
    excp_req_i = 1; excp_op1_i = 32'h300; excp_op2_i = 32'hC;
    settle();
    check("t2_c2_src", {62'd0, flush_src_o}, 64'd3);
    check("t2_c2_op1", {32'd0, flush_op1_o}, 64'h200);
    check("t2_c2_eack", {63'd0, excp_ack_o}, 64'd0);
    tick();
    brch_op1_i = 32'hDEAD;
    settle();
    check("t2_c3_op1_hold", {32'd0, flush_op1_o}, 64'h200);
    tick();
    flush_ack_i = 1;
    settle();
    check("t2_c4_acks", {60'd0, excp_ack_o, trap_ack_o, brch_ack_o, flush_pulse_o}, 64'b0011);
    tick();
    brch_req_i = 0; flush_ack_i = 0;
    settle();
    check("t2_c5_src", {62'd0, flush_src_o}, 64'd1);
    check("t2_c5_ops", {flush_op1_o, flush_op2_o}, {32'h300, 32'hC});
    flush_ack_i = 1;
    settle();
    check("t2_c5_eack", {63'd0, excp_ack_o}, 64'd1);
    tick();
    idle_inputs();
    settle();
    check("t2_cnt", {48'd0, flush_cnt_o}, 64'd3);

    // 3: trap pulse alongside branch; trap granted from the following cycle
    trap_pulse_i = 1; trap_op1_i = 32'h100; trap_op2_i = 32'h10;
    brch_req_i = 1; brch_op1_i = 32'h220; flush_ack_i = 1;
    settle();
    check("t3_c0_src", {62'd0, flush_src_o}, 64'd3);
    check("t3_c0_back", {63'd0, brch_ack_o}, 64'd1);
    tick();
    trap_pulse_i = 0; trap_op1_i = '0; trap_op2_i = '0; brch_req_i = 0;
    settle();
    check("t3_c1_pend", {63'd0, trap_pend_o}, 64'd1);
    check("t3_c1_src", {62'd0, flush_src_o}, 64'd2);
    check("t3_c1_ops", {flush_op1_o, flush_op2_o}, {32'h100, 32'h10});
    check("t3_c1_tack", {63'd0, trap_ack_o}, 64'd1);
    tick();
    flush_ack_i = 0;
    settle();
    check("t3_c2_pend", {63'd0, trap_pend_o}, 64'd0);
    check("t3_c2_req", {63'd0, flush_req_o}, 64'd0);

    // 4: second trap pulse while the first is still pending is dropped
    trap_pulse_i = 1; trap_op1_i = 32'h400; trap_op2_i = 32'h20;
    tick();
    trap_pulse_i = 0;
    settle();
    check("t4_c1_src", {62'd0, flush_src_o}, 64'd2);
    tick();
    trap_pulse_i = 1; trap_op1_i = 32'h500; trap_op2_i = 32'h30;
    tick();
    trap_pulse_i = 0;
    settle();
    check("t4_drop", {63'd0, trap_drop_o}, 64'd1);
    check("t4_ops", {flush_op1_o, flush_op2_o}, {32'h400, 32'h20});
    flush_ack_i = 1;
    settle();
    check("t4_tack", {63'd0, trap_ack_o}, 64'd1);
    tick();
    idle_inputs();
    settle();
    check("t4_pend_clr", {63'd0, trap_pend_o}, 64'd0);
    check("t4_cnt", {48'd0, flush_cnt_o}, 64'd6);

    // 5: watchdog fires after 255 WAIT cycles with the grant still held
    excp_req_i = 1; excp_op1_i = 32'h600; excp_op2_i = 32'h40;
    tick();
    excp_op1_i = 32'hBEEF;
    for (int i = 0; i < 250; i++) tick();
    check("t5_no_tmo_yet", {63'd0, tmo_err_o}, 64'd0);
    for (int i = 0; i < 10; i++) tick();
    check("t5_tmo", {63'd0, tmo_err_o}, 64'd1);
    check("t5_req", {63'd0, flush_req_o}, 64'd1);
    check("t5_ops", {flush_op1_o, flush_op2_o}, {32'h600, 32'h40});
    flush_ack_i = 1;
    settle();
    check("t5_eack", {63'd0, excp_ack_o}, 64'd1);
    tick();
    idle_inputs();
    settle();
    check("t5_tmo_sticky", {63'd0, tmo_err_o}, 64'd1);
    check("t5_cnt", {48'd0, flush_cnt_o}, 64'd7);

    // 6: clear, saturate, clear-over-increment, then reset in WAIT
    cnt_clr_i = 1;
    tick();
    cnt_clr_i = 0;
    settle();
    check("t6_clr", {48'd0, flush_cnt_o}, 64'd0);
    excp_req_i = 1; flush_ack_i = 1;
    for (int i = 0; i < 65535; i++) tick();
    check("t6_full", {48'd0, flush_cnt_o}, 64'hFFFF);
    tick();
    check("t6_sat", {48'd0, flush_cnt_o}, 64'hFFFF);
    cnt_clr_i = 1;
    settle();
    check("t6_pulse_w_clr", {63'd0, flush_pulse_o}, 64'd1);
    tick();
    idle_inputs();
    settle();
    check("t6_clr_prio", {48'd0, flush_cnt_o}, 64'd0);
    brch_req_i = 1; brch_op1_i = 32'h700; brch_op2_i = 32'h50;
    tick();
    settle();
    check("t6_wait_req", {63'd0, flush_req_o}, 64'd1);
    rst_n = 0; brch_req_i = 0;
    tick();
    rst_n = 1;
    settle();
    check_all_zero("t6_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
